// File: rtl/pn532_i2c_pkg.sv
// Shared definitions for the PN532 I2C target and the bridge's I2C initiator.
package pn532_i2c_pkg;

    localparam logic [6:0] PN532_I2C_ADDR = 7'h24;

    // Bit positions inside the status byte.
    localparam int unsigned STAT_START_SEEN  = 7;
    localparam int unsigned STAT_STOP_SEEN   = 6;
    localparam int unsigned STAT_ADDR_MATCH  = 5;
    localparam int unsigned STAT_RD_NWR      = 4;
    localparam int unsigned STAT_TX_UNDERRUN = 3;
    localparam int unsigned STAT_NACK_SEEN   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser plus SCL edge and START/STOP detection for an I2C bus pair.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;

    // Shift chains; the extra prev flop gives one-cycle edge pulses.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_sync_q[SYNC_STAGES-1];
        sda_prev_d = sda_sync_q[SYNC_STAGES-1];
    end

    // Idle bus is high, so the chains reset to 1 to avoid false edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_o      = scl_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_c = scl_o & ~scl_prev_q;
    assign scl_fall_c = ~scl_o & scl_prev_q;
    assign start_c    = scl_o & scl_prev_q & sda_prev_q & ~sda_o;
    assign stop_c     = scl_o & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/pn532_i2c_target.sv
// I2C target emulating the PN532 side of the FireLink link.
module pn532_i2c_target
    import pn532_i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = PN532_I2C_ADDR,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic [7:0] status
);

    logic scl_s, sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (CLOCK_50),
        .reset      (reset),
        .scl_i      (scl),
        .sda_i      (sda),
        .scl_o      (scl_s),
        .sda_o      (sda_s),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       byte_done_q, byte_done_d;
    logic       ack_q, ack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rd_nwr_q, rd_nwr_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ready_q, tx_ready_d;
    logic       busy_q, busy_d;
    logic       start_seen_q, start_seen_d;
    logic       stop_seen_q, stop_seen_d;
    logic       addr_match_q, addr_match_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic       nack_seen_q, nack_seen_d;
    logic       do_load;
    logic [7:0] load_byte;

    // Next-state and output logic; START/STOP override every state.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        byte_done_d   = byte_done_q;
        ack_d         = ack_q;
        sda_oe_d      = sda_oe_q;
        rd_nwr_d      = rd_nwr_q;
        rx_valid_d    = 1'b0;
        tx_ready_d    = 1'b0;
        busy_d        = busy_q;
        start_seen_d  = start_seen_q;
        stop_seen_d   = stop_seen_q;
        addr_match_d  = addr_match_q;
        tx_underrun_d = tx_underrun_q;
        nack_seen_d   = nack_seen_q;
        do_load       = 1'b0;
        load_byte     = tx_valid ? tx_data : FILL_BYTE;

        if (start_c) begin
            state_d       = ST_ADDR;
            bit_cnt_d     = 3'd0;
            byte_done_d   = 1'b0;
            ack_d         = 1'b0;
            sda_oe_d      = 1'b0;
            rd_nwr_d      = 1'b0;
            start_seen_d  = 1'b1;
            stop_seen_d   = 1'b0;
            addr_match_d  = 1'b0;
            tx_underrun_d = 1'b0;
            nack_seen_d   = 1'b0;
        end else if (stop_c) begin
            state_d     = ST_IDLE;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            stop_seen_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_IGNORE: ;
                ST_ADDR: begin
                    if (scl_rise_c) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall_c && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            state_d      = ST_ADDR_ACK;
                            sda_oe_d     = 1'b1;
                            rd_nwr_d     = shift_q[0];
                            addr_match_d = 1'b1;
                            busy_d       = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_c) begin
                        sda_oe_d = 1'b0;
                        if (rd_nwr_q) begin
                            do_load = 1'b1;
                        end else begin
                            state_d     = ST_WRITE;
                            bit_cnt_d   = 3'd0;
                            byte_done_d = 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise_c) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d   = {shift_q[6:0], sda_s};
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall_c && byte_done_q) begin
                        state_d     = ST_WRITE_ACK;
                        sda_oe_d    = 1'b1;
                        byte_done_d = 1'b0;
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall_c) begin
                        state_d   = ST_WRITE;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_READ: begin
                    // bit_cnt counts bits already driven; wrap to 0 means all 8 are out.
                    if (scl_fall_c) begin
                        if (bit_cnt_q == 3'd0) begin
                            state_d  = ST_READ_ACK;
                            sda_oe_d = 1'b0;
                            ack_d    = 1'b0;
                        end else begin
                            sda_oe_d   = ~tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise_c) begin
                        if (!sda_s) begin
                            ack_d = 1'b1;
                        end else begin
                            nack_seen_d = 1'b1;
                            state_d     = ST_IGNORE;
                        end
                    end else if (scl_fall_c && ack_q) begin
                        do_load = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Fetch the next read byte and put its MSB on the bus.
            if (do_load) begin
                tx_ready_d = tx_valid;
                if (!tx_valid) tx_underrun_d = 1'b1;
                sda_oe_d   = ~load_byte[7];
                tx_shift_d = {load_byte[6:0], 1'b0};
                bit_cnt_d  = 3'd1;
                state_d    = ST_READ;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            tx_shift_q    <= 8'd0;
            rx_data_q     <= 8'd0;
            byte_done_q   <= 1'b0;
            ack_q         <= 1'b0;
            sda_oe_q      <= 1'b0;
            rd_nwr_q      <= 1'b0;
            rx_valid_q    <= 1'b0;
            tx_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            start_seen_q  <= 1'b0;
            stop_seen_q   <= 1'b0;
            addr_match_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            nack_seen_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            byte_done_q   <= byte_done_d;
            ack_q         <= ack_d;
            sda_oe_q      <= sda_oe_d;
            rd_nwr_q      <= rd_nwr_d;
            rx_valid_q    <= rx_valid_d;
            tx_ready_q    <= tx_ready_d;
            busy_q        <= busy_d;
            start_seen_q  <= start_seen_d;
            stop_seen_q   <= stop_seen_d;
            addr_match_q  <= addr_match_d;
            tx_underrun_q <= tx_underrun_d;
            nack_seen_q   <= nack_seen_d;
        end
    end

    // Status byte assembly from the sticky flags.
    always_comb begin
        status                   = 8'd0;
        status[STAT_START_SEEN]  = start_seen_q;
        status[STAT_STOP_SEEN]   = stop_seen_q;
        status[STAT_ADDR_MATCH]  = addr_match_q;
        status[STAT_RD_NWR]      = rd_nwr_q;
        status[STAT_TX_UNDERRUN] = tx_underrun_q;
        status[STAT_NACK_SEEN]   = nack_seen_q;
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pn532_i2c_target.sv
// Directed plus randomized bench: bit-banged I2C controller against a transaction-level model.
module tb_pn532_i2c_target;

    localparam int unsigned Q = 6;
    localparam logic [6:0]  ADDR = 7'h24;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       ctl_low;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [7:0] status;

    always #10 clk = ~clk;

    pullup (sda);
    assign sda = ctl_low ? 1'b0 : 1'bz;

    pn532_i2c_target dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .status   (status)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Observed streams.
    logic [7:0]  rx_log [$];
    int unsigned tx_ready_total = 0;

    always @(negedge clk) begin
        if (rx_valid) rx_log.push_back(rx_data);
        if (tx_ready) tx_ready_total++;
    end

    // Source model: tx_arr[0..tx_len-1] presented in order while tx_en.
    logic [7:0]  tx_arr [8];
    int unsigned tx_base;
    int unsigned tx_len;
    logic        tx_en;
    int unsigned tx_idx;

    always_comb begin
        tx_idx   = tx_ready_total - tx_base;
        tx_valid = tx_en && (tx_idx < tx_len);
        tx_data  = tx_arr[tx_idx[2:0]];
    end

    logic [7:0] exp_rx [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] stat(input bit st, input bit sp, input bit m,
                                         input bit r, input bit u, input bit n);
        return {st, sp, m, r, u, n, 2'b00};
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic drive_low, output logic line);
        ctl_low = drive_low; tick(Q);
        scl = 1'b1;          tick(Q);
        line = sda;          tick(Q);
        scl = 1'b0;          tick(Q);
    endtask

    task automatic start_cond();
        ctl_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        ctl_low = 1'b1; tick(Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic stop_cond();
        ctl_low = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        ctl_low = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic l;
        for (int i = 7; i >= 0; i--) bus_bit(~b[i], l);
        bus_bit(1'b0, l);
        acked = ~l;
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b0, l);
            d[i] = l;
        end
        bus_bit(send_ack, l);
    endtask

    task automatic check_rx(input string tag);
        check(tag, rx_log.size(), exp_rx.size());
        for (int i = 0; i < rx_log.size() && i < exp_rx.size(); i++)
            check(tag, rx_log[i], exp_rx[i]);
    endtask

    initial begin
        logic        ack;
        logic        l;
        logic [7:0]  d;
        logic [6:0]  a;
        logic [7:0]  wb;
        int unsigned n;
        bit          match;
        int unsigned base;
        logic [7:0]  pat [4];

        reset = 1'b1; scl = 1'b1; ctl_low = 1'b0;
        tx_en = 1'b0; tx_len = 0; tx_base = 0;
        for (int i = 0; i < 8; i++) tx_arr[i] = 8'h00;
        tick(4);
        reset = 1'b0;
        tick(3);
        check("rst_status", status, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_sda", sda, 1'b1);

        // Directed write of four bytes.
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h01; pat[3] = 8'hD4;
        start_cond();
        write_byte({ADDR, 1'b0}, ack);
        check("w_addr_ack", ack, 1'b1);
        check("w_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            write_byte(pat[i], ack);
            check("w_data_ack", ack, 1'b1);
            exp_rx.push_back(pat[i]);
        end
        stop_cond();
        check("w_busy_stop", busy, 1'b0);
        check("w_status", status, stat(1, 1, 1, 0, 0, 0));
        check_rx("w_rx");

        // Address mismatch 0x25.
        start_cond();
        write_byte({7'h25, 1'b0}, ack);
        check("mm_ack", ack, 1'b0);
        check("mm_busy", busy, 1'b0);
        write_byte(8'h5A, ack);
        check("mm_data_ack", ack, 1'b0);
        stop_cond();
        check("mm_status", status, stat(1, 1, 0, 0, 0, 0));
        check_rx("mm_rx");

        // Randomized writes, matching or not.
        for (int t = 0; t < 5; t++) begin
            a = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) a = ADDR;
            match = (a == ADDR);
            n = $urandom_range(1, 4);
            start_cond();
            write_byte({a, 1'b0}, ack);
            check("rw_addr_ack", ack, match);
            check("rw_busy", busy, match);
            for (int i = 0; i < n; i++) begin
                wb = 8'($urandom);
                write_byte(wb, ack);
                check("rw_data_ack", ack, match);
                if (match) exp_rx.push_back(wb);
            end
            stop_cond();
            check("rw_status", status, stat(1, 1, match, 0, 0, 0));
            check("rw_busy_stop", busy, 1'b0);
            check_rx("rw_rx");
        end

        // Directed read 0x01 (ACK), 0x80 (NACK), then ignored clocks.
        tx_arr[0] = 8'h01; tx_arr[1] = 8'h80; tx_len = 2; tx_base = tx_ready_total; tx_en = 1'b1;
        base = tx_ready_total;
        start_cond();
        write_byte({ADDR, 1'b1}, ack);
        check("r_addr_ack", ack, 1'b1);
        read_byte(1'b1, d);
        check("r_byte0", d, 8'h01);
        read_byte(1'b0, d);
        check("r_byte1", d, 8'h80);
        check("r_status_nack", status, stat(1, 0, 1, 1, 0, 1));
        read_byte(1'b0, d);
        check("r_ignore_line", d, 8'hFF);
        check("r_tx_ready_cnt", tx_ready_total - base, 2);
        stop_cond();
        check("r_busy_stop", busy, 1'b0);
        tx_en = 1'b0;

        // Randomized reads, last byte NACKed.
        for (int t = 0; t < 3; t++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < 8; i++) tx_arr[i] = 8'($urandom);
            tx_len = n; tx_base = tx_ready_total; tx_en = 1'b1;
            base = tx_ready_total;
            start_cond();
            write_byte({ADDR, 1'b1}, ack);
            check("rr_addr_ack", ack, 1'b1);
            for (int i = 0; i < n; i++) begin
                read_byte(i != n - 1, d);
                check("rr_data", d, tx_arr[i]);
            end
            check("rr_tx_ready_cnt", tx_ready_total - base, n);
            check("rr_status", status, stat(1, 0, 1, 1, 0, 1));
            stop_cond();
            tx_en = 1'b0;
        end

        // Underrun: no source data returns the fill byte.
        tx_len = 0; tx_base = tx_ready_total; tx_en = 1'b0;
        base = tx_ready_total;
        start_cond();
        write_byte({ADDR, 1'b1}, ack);
        check("u_addr_ack", ack, 1'b1);
        read_byte(1'b0, d);
        check("u_fill", d, 8'hFF);
        check("u_tx_ready_cnt", tx_ready_total - base, 0);
        check("u_status", status, stat(1, 0, 1, 1, 1, 1));
        stop_cond();

        // Write then repeated START into a read.
        tx_arr[0] = 8'h5C; tx_len = 1; tx_base = tx_ready_total; tx_en = 1'b1;
        start_cond();
        write_byte({ADDR, 1'b0}, ack);
        check("rs_addr_ack", ack, 1'b1);
        write_byte(8'h4A, ack);
        check("rs_data_ack", ack, 1'b1);
        exp_rx.push_back(8'h4A);
        ctl_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        ctl_low = 1'b1; tick(Q);
        check("rs_status_restart", status, stat(1, 0, 0, 0, 0, 0));
        scl = 1'b0;     tick(Q);
        write_byte({ADDR, 1'b1}, ack);
        check("rs_raddr_ack", ack, 1'b1);
        read_byte(1'b0, d);
        check("rs_read", d, 8'h5C);
        stop_cond();
        check("rs_status", status, stat(1, 1, 1, 1, 0, 1));
        check_rx("rs_rx");
        tx_en = 1'b0;

        // Reset while the target is driving the address ACK.
        start_cond();
        wb = {ADDR, 1'b0};
        for (int i = 7; i >= 0; i--) bus_bit(~wb[i], l);
        ctl_low = 1'b0; tick(Q);
        check("mr_ack_driven", sda, 1'b0);
        reset = 1'b1;
        tick(1);
        check("mr_sda_released", sda, 1'b1);
        check("mr_busy", busy, 1'b0);
        check("mr_status", status, 8'h00);
        check("mr_rx_data", rx_data, 8'h00);
        check("mr_rx_valid", rx_valid, 1'b0);
        check("mr_tx_ready", tx_ready, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(2);
        start_cond();
        write_byte({ADDR, 1'b0}, ack);
        check("mr_next_ack", ack, 1'b1);
        write_byte(8'h3C, ack);
        check("mr_next_data_ack", ack, 1'b1);
        exp_rx.push_back(8'h3C);
        stop_cond();
        check("mr_next_status", status, stat(1, 1, 1, 0, 0, 0));
        check_rx("mr_rx");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
